// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: 64 KB window, configurable wait states,
// two-cycle ERROR response, byte/halfword/word access with pipelining.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_commit;
    logic [15:0]           w_hi;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_merged;
    logic                  w_unused;

    assign w_unused = &{1'b0, HADDR[31:16], HTRANS[0]};

    assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign w_accept = HSEL & HREADY & HTRANS[1] & w_ready;
    assign w_hi     = HADDR[15:0] >> (ADDR_WIDTH + 2);
    assign w_idx    = HADDR[ADDR_WIDTH+1:2];
    assign r_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_commit = (r_state == S_LAST) & r_write;

    assign w_err = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd1) & HADDR[0])
                 | ((HSIZE == 3'd2) & (|HADDR[1:0]))
                 | (|w_hi);

    always_comb begin
        w_be = 4'b1111;
        unique case (1'b1)
            (r_size == 3'd0): w_be = 4'b0001 << r_addr[1:0];
            (r_size == 3'd1): w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default:          w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_merged = r_mem[r_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_LAST, S_ERR2: begin
                if (!w_accept)          w_next = S_IDLE;
                else if (w_err)         w_next = S_ERR1;
                else if (WAIT_STATES>0) w_next = S_WAIT;
                else                    w_next = S_LAST;
            end
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_LAST;
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= HADDR[15:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
                r_cnt   <= CNT_LOAD;
                // Forward a same-word write committing on this edge.
                r_rdata <= (w_commit && (r_idx == w_idx)) ?
                           w_merged : r_mem[w_idx];
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_idx] <= w_merged;
    end

    always_comb begin
        HREADYOUT = w_ready;
        HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
        HRDATA    = '0;
        if (((r_state == S_WAIT) || (r_state == S_LAST)) && !r_write)
            HRDATA = r_rdata;
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomised pipelined-master bench for ahb_lite_sram_slave against a
// byte-addressed reference memory; covers WAIT_STATES of 1 and 0.
module tb_ahb_lite_sram_slave;

    typedef struct {
        bit        nt;
        bit        w;
        bit [2:0]  sz;
        bit [31:0] a;
        bit [31:0] d;
        bit        err;
    } xfer_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        nrdy_force;
    int          which;

    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic        hready    [2];
    logic        hsel_k    [2];

    logic [7:0]  mb [2][4096];
    xfer_t       q[$];
    logic [31:0] last_rd;
    int          err_seen;
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    assign hready[0] = nrdy_force ? 1'b0 : hreadyout[0];
    assign hready[1] = nrdy_force ? 1'b0 : hreadyout[1];
    assign hsel_k[0] = hsel && (which == 0);
    assign hsel_k[1] = hsel && (which == 1);

    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .resetn(resetn), .HSEL(hsel_k[0]), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready[0]), .HRDATA(hrdata[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .resetn(resetn), .HSEL(hsel_k[1]), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(hready[1]), .HRDATA(hrdata[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_err(bit [2:0] sz, bit [31:0] a);
        int lo = int'(a & 32'hFFFF);
        if (sz > 2) return 1'b1;
        if (lo % (1 << sz) != 0) return 1'b1;
        return lo >= 4096;
    endfunction

    function automatic logic [31:0] mword(int d, bit [31:0] a);
        int base = int'(a & 32'hFFC);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = mb[d][base + i];
        return v;
    endfunction

    task automatic mwrite(int d, xfer_t t);
        for (int i = 0; i < (1 << t.sz); i++) begin
            int ba = int'(t.a & 32'hFFF) + i;
            mb[d][ba] = t.d[8*(ba % 4) +: 8];
        end
    endtask

    task automatic push(bit w, bit [2:0] sz, bit [31:0] a, bit [31:0] d);
        xfer_t t = '{nt: 1'b0, w: w, sz: sz, a: a, d: d, err: 1'b0};
        q.push_back(t);
    endtask

    task automatic next_ap(output xfer_t ap, output bit ap_v);
        xfer_t e;
        ap = '{default: 0};
        ap_v = 1'b0;
        hwrite = $urandom_range(0, 1);
        hsize  = 3'($urandom_range(0, 2));
        haddr  = $urandom;
        if (q.size() == 0) begin
            hsel = 1'b0;
            htrans = 2'b00;
            return;
        end
        e = q.pop_front();
        if (e.nt) begin
            hsel = $urandom_range(0, 1);
            htrans = 2'($urandom_range(0, 1));
            return;
        end
        ap = e;
        ap.err = is_err(e.sz, e.a);
        ap_v = 1'b1;
        hsel = 1'b1;
        htrans = {1'b1, 1'($urandom_range(0, 1))};
        haddr = {16'($urandom), e.a[15:0]};
        hwrite = e.w;
        hsize = e.sz;
    endtask

    // Pipelined master: next address phase overlaps the current data phase.
    task automatic run();
        xfer_t ap, dp;
        bit ap_v, dp_v;
        int cyc, guard;
        int ws = (which == 0) ? 1 : 0;
        logic r, rs;
        logic [31:0] rd;
        dp = '{default: 0};
        dp_v = 1'b0;
        cyc = 0;
        guard = 0;
        @(posedge clk); #1;
        next_ap(ap, ap_v);
        while ((ap_v || dp_v || q.size() > 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
            r  = hreadyout[which];
            rs = hresp[which];
            rd = hrdata[which];
            if (dp_v) begin
                cyc++;
                if (!r) begin
                    chk("wait_resp", 32'(rs), 32'(dp.err));
                end else begin
                    chk("latency", cyc, dp.err ? 2 : ws + 1);
                    chk("resp", 32'(rs), 32'(dp.err));
                    if (rs) err_seen++;
                    if (dp.err || dp.w) begin
                        chk("rdata_zero", rd, 32'h0);
                    end else begin
                        chk("rdata", rd, mword(which, dp.a));
                        last_rd = rd;
                    end
                    if (dp.w && !dp.err) mwrite(which, dp);
                end
            end else begin
                chk("idle_ready", 32'(r), 32'h1);
                chk("idle_resp", 32'(rs), 32'h0);
                chk("idle_rdata", rd, 32'h0);
            end
            @(posedge clk); #1;
            if (r) begin
                dp_v = ap_v;
                dp = ap;
                cyc = 0;
                hwdata = (dp_v && dp.w) ? dp.d : $urandom;
                next_ap(ap, ap_v);
            end
        end
        if (guard >= 20000) chk("timeout", 32'h1, 32'h0);
    endtask

    task automatic rand_traffic(int n);
        for (int i = 0; i < n; i++) begin
            xfer_t t;
            t = '{default: 0};
            if ($urandom_range(0, 9) == 0) begin
                t.nt = 1'b1;
            end else begin
                t.w = $urandom_range(0, 1);
                t.sz = ($urandom_range(0, 15) == 0) ?
                       3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                t.a = $urandom_range(0, 4095);
                if (t.sz <= 2 && $urandom_range(0, 7) != 0)
                    t.a = t.a & ~((32'h1 << t.sz) - 1);
                if ($urandom_range(0, 15) == 0)
                    t.a = t.a | (32'($urandom_range(1, 15)) << 12);
                t.d = $urandom;
            end
            q.push_back(t);
        end
        run();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        err_seen = 0;
        last_rd = '0;
        which = 0;
        resetn = 1'b0;
        hsel = 1'b0;
        haddr = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize = 3'd0;
        hwdata = '0;
        nrdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(hreadyout[k]), 32'h1);
            chk("rst_resp", 32'(hresp[k]), 32'h0);
            chk("rst_rdata", hrdata[k], 32'h0);
        end
        resetn = 1'b1;

        for (int k = 0; k < 2; k++) begin
            which = k;
            for (int w = 0; w < 1024; w++) push(1, 2, 32'(w * 4), $urandom);
            run();
        end

        which = 0;
        push(1, 2, 32'h10, 32'hDEADBEEF);
        push(0, 2, 32'h10, 32'h0);
        run();
        chk("t1_read", last_rd, 32'hDEADBEEF);

        push(1, 0, 32'h13, 32'hAA000000);
        push(1, 1, 32'h10, 32'h00001234);
        push(0, 2, 32'h10, 32'h0);
        run();
        chk("t2_merge", last_rd, 32'hAAAD1234);

        which = 1;
        push(1, 2, 32'h20, 32'h11223344);
        push(0, 2, 32'h20, 32'h0);
        run();
        chk("t3_bypass", last_rd, 32'h11223344);

        which = 0;
        err_seen = 0;
        push(0, 2, 32'h0002, 32'h0);
        push(1, 1, 32'h0101, 32'hFFFFFFFF);
        push(1, 2, 32'h1000, 32'h55555555);
        push(0, 2, 32'h0100, 32'h0);
        push(0, 2, 32'h0000, 32'h0);
        run();
        chk("t4_err_count", err_seen, 3);

        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h10; hwdata = 32'hFFFFFFFF;
        repeat (2) begin
            @(negedge clk);
            chk("t5_idle_ready", 32'(hreadyout[0]), 32'h1);
            chk("t5_idle_resp", 32'(hresp[0]), 32'h0);
        end
        @(posedge clk); #1;
        nrdy_force = 1'b1; htrans = 2'b10;
        @(posedge clk); #1;
        nrdy_force = 1'b0; htrans = 2'b00;
        @(negedge clk);
        chk("t5_nrdy_ready", 32'(hreadyout[0]), 32'h1);
        chk("t5_nrdy_resp", 32'(hresp[0]), 32'h0);
        push(0, 2, 32'h10, 32'h0);
        run();
        chk("t5_unchanged", last_rd, 32'hAAAD1234);

        push(1, 2, 32'h30, 32'h0);
        run();
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h30;
        @(posedge clk); #1;
        htrans = 2'b00; hsel = 1'b0; hwdata = 32'hCAFEF00D;
        chk("t6_in_wait", 32'(hreadyout[0]), 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(hreadyout[0]), 32'h1);
        chk("t6_rst_resp", 32'(hresp[0]), 32'h0);
        chk("t6_rst_rdata", hrdata[0], 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        push(0, 2, 32'h30, 32'h0);
        run();
        chk("t6_no_commit", last_rd, 32'h0);

        for (int k = 0; k < 2; k++) begin
            which = k;
            rand_traffic(400);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
